// File: rtl/cpu_clk_ctrl.sv
// Board-clock run controller for the OSECPU core: divided CPU tick enable,
// power-on CPU reset, and debounced run/halt and single-step buttons.
module cpu_clk_ctrl #(
  parameter int DIV_BIT      = 24,
  parameter int DEBOUNCE_BIT = 16,
  parameter int RESET_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_run,
  input  logic        btn_step,
  input  logic        halt_req,
  output logic        cpu_en,
  output logic        cpu_reset,
  output logic [1:0]  mode,
  output logic [15:0] tick_count
);

  localparam int DW  = DIV_BIT + 1;
  localparam int RCW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RCW-1:0] RC_LAST = RCW'(RESET_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RST  = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10,
    ST_STEP = 2'b11
  } state_t;

  logic [1:0] w_btn;
  logic [1:0] w_press;
  logic       w_run_press;
  logic       w_step_press;
  logic       w_div_wrap;
  logic       w_tick;

  state_t          r_state;
  logic [DW-1:0]   r_div;
  logic [RCW-1:0]  r_rst_cnt;
  logic            r_cpu_en;
  logic            r_cpu_reset;
  logic [15:0]     r_tick_count;

  assign w_btn = {btn_step, btn_run};

  // The counter measures how long the synchronised level has held a value
  // different from the debounced one; any return to the old level restarts it.
  for (genvar g = 0; g < 2; g++) begin : g_btn
    logic [1:0]              r_sync;
    logic [DEBOUNCE_BIT-1:0] r_cnt;
    logic                    r_db;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_sync <= '0;
        r_cnt  <= '0;
        r_db   <= 1'b0;
      end else begin
        r_sync <= {r_sync[0], w_btn[g]};
        if (r_sync[1] == r_db) begin
          r_cnt <= '0;
        end else if (r_cnt == '1) begin
          r_db  <= r_sync[1];
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + DEBOUNCE_BIT'(1);
        end
      end
    end

    // Press fires on the cycle the debounced level is about to rise.
    assign w_press[g] = r_sync[1] & ~r_db & (r_cnt == '1);
  end

  assign w_run_press  = w_press[0];
  assign w_step_press = w_press[1];
  assign w_div_wrap   = (r_div == '1);

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_tick = 1'b0;
    case (r_state)
      ST_RUN:  w_tick = w_div_wrap & ~w_run_press & ~halt_req;
      ST_HALT: w_tick = ~w_run_press & w_step_press;
      default: w_tick = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_RST;
      r_div        <= '0;
      r_rst_cnt    <= '0;
      r_cpu_en     <= 1'b0;
      r_cpu_reset  <= 1'b1;
      r_tick_count <= '0;
    end else begin
      r_cpu_en     <= w_tick;
      r_tick_count <= r_tick_count + 16'(w_tick);
      case (r_state)
        ST_RST: begin
          if (r_rst_cnt == RC_LAST) begin
            r_state     <= ST_RUN;
            r_cpu_reset <= 1'b0;
            r_div       <= '0;
          end else begin
            r_rst_cnt <= r_rst_cnt + RCW'(1);
          end
        end
        ST_RUN: begin
          if (w_run_press || halt_req) begin
            r_state <= ST_HALT;
          end else begin
            r_div <= r_div + DW'(1);
          end
        end
        ST_HALT: begin
          // A run press always takes priority over step, even when halt_req blocks it.
          if (w_run_press) begin
            if (!halt_req) begin
              r_state <= ST_RUN;
              r_div   <= '0;
            end
          end else if (w_step_press) begin
            r_state <= ST_STEP;
          end
        end
        ST_STEP: r_state <= ST_HALT;
        default: r_state <= ST_RST;
      endcase
    end
  end

  assign cpu_en     = r_cpu_en;
  assign cpu_reset  = r_cpu_reset;
  assign mode       = r_state;
  assign tick_count = r_tick_count;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Self-checking bench for cpu_clk_ctrl: an event scoreboard of every mode
// change and tick, plus direct latency checks on each scenario.
module tb_cpu_clk_ctrl;

  logic        clk;
  logic        reset;
  logic        btn_run;
  logic        btn_step;
  logic        halt_req;
  logic        cpu_en;
  logic        cpu_reset;
  logic [1:0]  mode;
  logic [15:0] tick_count;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [1:0]  mode;
    logic        en;
    logic [15:0] tick;
    logic        rst;
  } ev_t;

  ev_t sb[$];

  cpu_clk_ctrl #(
    .DIV_BIT     (2),
    .DEBOUNCE_BIT(2),
    .RESET_CYCLES(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_run   (btn_run),
    .btn_step  (btn_step),
    .halt_req  (halt_req),
    .cpu_en    (cpu_en),
    .cpu_reset (cpu_reset),
    .mode      (mode),
    .tick_count(tick_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic ev_t mk(input logic [1:0] m, input logic e, input logic [15:0] t);
    ev_t ev;
    ev.mode = m;
    ev.en   = e;
    ev.tick = t;
    ev.rst  = 1'b0;
    return ev;
  endfunction

  // Logs every mode change and every tick, comparing against the expected queue.
  initial begin : monitor
    logic [1:0] last_mode;
    ev_t got;
    ev_t exp;
    last_mode = 2'b00;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        last_mode = 2'b00;
      end else if (cpu_en || mode != last_mode) begin
        got.mode  = mode;
        got.en    = cpu_en;
        got.tick  = tick_count;
        got.rst   = cpu_reset;
        last_mode = mode;
        if (sb.size() == 0) begin
          check("sb_unexpected_event", 32'(sb.size()), 32'd1);
        end else begin
          exp = sb.pop_front();
          check("sb_event", 32'(got), 32'(exp));
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic wait_mode(input logic [1:0] m, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (mode != m && n < 40);
  endtask

  task automatic wait_en(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cpu_en && n < 40);
  endtask

  task automatic release_reset();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_hold", 32'({cpu_reset, mode}), 32'b100);
    end
    @(negedge clk);
    check("rst_exit", 32'({cpu_reset, mode}), 32'b001);
  endtask

  initial begin : stim
    int n;
    reset    = 1'b1;
    btn_run  = 1'b0;
    btn_step = 1'b0;
    halt_req = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_mode", 32'(mode), 32'd0);
    check("reset_cpu_reset", 32'(cpu_reset), 32'd1);
    check("reset_cpu_en", 32'(cpu_en), 32'd0);
    check("reset_tick", 32'(tick_count), 32'd0);

    // Scenario 1: power-on sequence and free-running ticks
    sb.push_back(mk(2'b01, 1'b0, 16'd0));
    for (int i = 1; i <= 3; i++) sb.push_back(mk(2'b01, 1'b1, 16'(i)));
    release_reset();
    for (int i = 1; i <= 3; i++) begin
      wait_en(n);
      check("run_tick_period", 32'(n), 32'd8);
    end
    check("tick_after_24", 32'(tick_count), 32'd3);

    // Scenario 2: clean run press halts, bounce is rejected
    sb.push_back(mk(2'b10, 1'b0, 16'd3));
    btn_run = 1'b1;
    wait_mode(2'b10, n);
    check("run_press_latency", 32'(n), 32'd6);
    btn_run = 1'b0;
    repeat (12) @(negedge clk);
    check("halt_stays", 32'(mode), 32'd2);
    for (int i = 0; i < 10; i++) begin
      btn_run = ~btn_run;
      @(negedge clk);
    end
    btn_run = 1'b0;
    repeat (8) @(negedge clk);
    check("bounce_ignored", 32'(mode), 32'd2);

    // Scenario 3: two single steps
    for (int i = 0; i < 2; i++) begin
      sb.push_back(mk(2'b11, 1'b1, 16'(4 + i)));
      sb.push_back(mk(2'b10, 1'b0, 16'(4 + i)));
      btn_step = 1'b1;
      wait_mode(2'b11, n);
      check("step_latency", 32'(n), 32'd6);
      check("step_en", 32'({cpu_en, tick_count}), 32'({1'b1, 16'(4 + i)}));
      btn_step = 1'b0;
      @(negedge clk);
      check("step_back_halt", 32'({mode, cpu_en}), 32'b100);
      repeat (8) @(negedge clk);
    end

    // Scenario 4: halt_req on the wrap cycle, blocked run press, resume
    sb.push_back(mk(2'b01, 1'b0, 16'd5));
    sb.push_back(mk(2'b10, 1'b0, 16'd5));
    btn_run = 1'b1;
    wait_mode(2'b01, n);
    check("resume_latency", 32'(n), 32'd6);
    btn_run = 1'b0;
    repeat (7) @(negedge clk);
    halt_req = 1'b1;
    @(negedge clk);
    check("halt_on_wrap", 32'({mode, cpu_en, tick_count}), 32'({2'b10, 1'b0, 16'd5}));
    btn_run = 1'b1;
    repeat (6) @(negedge clk);
    btn_run = 1'b0;
    repeat (8) @(negedge clk);
    check("halt_req_blocks_run", 32'(mode), 32'd2);
    halt_req = 1'b0;
    sb.push_back(mk(2'b01, 1'b0, 16'd5));
    sb.push_back(mk(2'b01, 1'b1, 16'd6));
    btn_run = 1'b1;
    wait_mode(2'b01, n);
    check("rerun_latency", 32'(n), 32'd6);
    btn_run = 1'b0;
    wait_en(n);
    check("rerun_first_tick", 32'(n), 32'd8);
    check("rerun_tick_count", 32'(tick_count), 32'd6);

    // Scenario 5: simultaneous run+step in HALT, then tick_count wrap
    sb.push_back(mk(2'b10, 1'b0, 16'd6));
    halt_req = 1'b1;
    @(negedge clk);
    check("halt_req_halts", 32'(mode), 32'd2);
    halt_req = 1'b0;
    sb.push_back(mk(2'b01, 1'b0, 16'd6));
    sb.push_back(mk(2'b01, 1'b1, 16'd0));
    btn_run  = 1'b1;
    btn_step = 1'b1;
    wait_mode(2'b01, n);
    check("run_beats_step", 32'({n[7:0], mode, cpu_en}), 32'({8'd6, 2'b01, 1'b0}));
    btn_run  = 1'b0;
    btn_step = 1'b0;
    force dut.r_tick_count = 16'hFFFF;
    @(negedge clk);
    check("no_step_cycle", 32'({mode, cpu_en}), 32'b010);
    release dut.r_tick_count;
    wait_en(n);
    check("wrap_tick_latency", 32'(n), 32'd7);
    check("tick_wraps_to_zero", 32'(tick_count), 32'd0);

    // Scenario 6: reset mid-divide and mid-debounce, then restart
    repeat (3) @(negedge clk);
    btn_run = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_state", 32'({mode, cpu_reset, cpu_en, tick_count}),
          32'({2'b00, 1'b1, 1'b0, 16'd0}));
    btn_run = 1'b0;
    repeat (2) @(negedge clk);
    sb.push_back(mk(2'b01, 1'b0, 16'd0));
    sb.push_back(mk(2'b01, 1'b1, 16'd1));
    release_reset();
    wait_en(n);
    check("restart_first_tick", 32'(n), 32'd8);
    check("restart_tick_count", 32'(tick_count), 32'd1);
    repeat (4) @(negedge clk);
    check("restart_still_run", 32'(mode), 32'd1);

    check("sb_leftover", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
